// File: rtl/header_writer_param.sv
// Image-header writer: computes width, height and area of a bounding box and
// writes them as fixed-width fields, one word per beat, from BASE_ADDR upward.
module header_writer_param #(
    parameter int                COORD_W     = 11,
    parameter int                FIELD_BYTES = 4,
    parameter int                WORD_W      = 8,
    parameter int                ADDR_W      = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter bit                BIG_ENDIAN  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] x_min,
    input  logic [COORD_W-1:0] x_max,
    input  logic [COORD_W-1:0] y_min,
    input  logic [COORD_W-1:0] y_max,
    input  logic               wr_ready,
    output logic               wren,
    output logic [ADDR_W-1:0]  addr,
    output logic [WORD_W-1:0]  wrdata,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [1:0]         state_dbg
);

    localparam int FIELD_W = FIELD_BYTES * 8;
    localparam int BPF     = FIELD_W / WORD_W;
    localparam int N       = 3 * BPF;
    localparam int AREA_W  = 2 * COORD_W;
    localparam int MW      = (AREA_W > FIELD_W) ? AREA_W : FIELD_W;
    localparam int CHUNK_W = (BPF > 1) ? $clog2(BPF) : 1;
    localparam logic [MW-1:0] FIELD_MAX = MW'({FIELD_W{1'b1}});

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_WRITE, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [COORD_W-1:0]   x_min_q, x_min_d, x_max_q, x_max_d;
    logic [COORD_W-1:0]   y_min_q, y_min_d, y_max_q, y_max_d;
    logic [FIELD_W-1:0]   fields_q [3];
    logic [FIELD_W-1:0]   fields_d [3];
    logic                 err_q, err_d;
    logic [ADDR_W-1:0]    beat_q, beat_d;
    logic [1:0]           fsel_q, fsel_d;
    logic [CHUNK_W-1:0]   chunk_q, chunk_d;

    logic [COORD_W-1:0]   w, h;
    logic [AREA_W-1:0]    area;
    logic [MW-1:0]        w_ext, h_ext, a_ext;
    logic                 clamp_x, clamp_y, sat_w, sat_h, sat_a;
    logic [CHUNK_W-1:0]   word_idx;
    int unsigned          lsb;

    always_comb begin
        state_d  = state_q;
        x_min_d  = x_min_q;
        x_max_d  = x_max_q;
        y_min_d  = y_min_q;
        y_max_d  = y_max_q;
        fields_d = fields_q;
        err_d    = err_q;
        beat_d   = beat_q;
        fsel_d   = fsel_q;
        chunk_d  = chunk_q;
        wren     = 1'b0;
        addr     = '0;
        wrdata   = '0;
        busy     = 1'b0;
        done     = 1'b0;

        // Bounds arithmetic works on the latched coordinates only.
        clamp_x  = x_max_q < x_min_q;
        clamp_y  = y_max_q < y_min_q;
        w        = clamp_x ? '0 : x_max_q - x_min_q;
        h        = clamp_y ? '0 : y_max_q - y_min_q;
        area     = AREA_W'(w) * AREA_W'(h);
        w_ext    = MW'(w);
        h_ext    = MW'(h);
        a_ext    = MW'(area);
        sat_w    = w_ext > FIELD_MAX;
        sat_h    = h_ext > FIELD_MAX;
        sat_a    = a_ext > FIELD_MAX;

        word_idx = BIG_ENDIAN ? (CHUNK_W'(BPF - 1) - chunk_q) : chunk_q;
        lsb      = int'(word_idx) * WORD_W;

        case (state_q)
            S_IDLE, S_DONE: begin
                done = (state_q == S_DONE);
                if (start) begin
                    x_min_d = x_min;
                    x_max_d = x_max;
                    y_min_d = y_min;
                    y_max_d = y_max;
                    err_d   = 1'b0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                busy        = 1'b1;
                fields_d[0] = sat_w ? '1 : FIELD_W'(w_ext);
                fields_d[1] = sat_h ? '1 : FIELD_W'(h_ext);
                fields_d[2] = sat_a ? '1 : FIELD_W'(a_ext);
                err_d       = clamp_x | clamp_y | sat_w | sat_h | sat_a;
                beat_d      = '0;
                fsel_d      = '0;
                chunk_d     = '0;
                state_d     = S_WRITE;
            end
            S_WRITE: begin
                busy   = 1'b1;
                wren   = 1'b1;
                addr   = BASE_ADDR + beat_q;
                wrdata = WORD_W'(fields_q[fsel_q] >> lsb);
                // Beat pointers move only on acceptance, so addr/wrdata hold through stalls.
                if (wr_ready) begin
                    if (beat_q == ADDR_W'(N - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                        if (chunk_q == CHUNK_W'(BPF - 1)) begin
                            chunk_d = '0;
                            fsel_d  = fsel_q + 2'd1;
                        end else begin
                            chunk_d = chunk_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            x_min_q  <= '0;
            x_max_q  <= '0;
            y_min_q  <= '0;
            y_max_q  <= '0;
            fields_q <= '{default: '0};
            err_q    <= 1'b0;
            beat_q   <= '0;
            fsel_q   <= '0;
            chunk_q  <= '0;
        end else begin
            state_q  <= state_d;
            x_min_q  <= x_min_d;
            x_max_q  <= x_max_d;
            y_min_q  <= y_min_d;
            y_max_q  <= y_max_d;
            fields_q <= fields_d;
            err_q    <= err_d;
            beat_q   <= beat_d;
            fsel_q   <= fsel_d;
            chunk_q  <= chunk_d;
        end
    end

    assign err       = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_header_writer_param.sv
// Bench for header_writer_param: three instances (byte big-endian, byte
// little-endian, 16-bit fields) driven with the same bounding boxes.
module tb_header_writer_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        wr_ready = 1'b1;
    logic [10:0] x_min = '0, x_max = '0, y_min = '0, y_max = '0;

    logic        be_wren, be_busy, be_done, be_err;
    logic [23:0] be_addr;
    logic [7:0]  be_wrdata;
    logic [1:0]  be_state;
    logic        le_wren, le_busy, le_done, le_err;
    logic [23:0] le_addr;
    logic [7:0]  le_wrdata;
    logic [1:0]  le_state;
    logic        f16_wren, f16_busy, f16_done, f16_err;
    logic [23:0] f16_addr;
    logic [15:0] f16_wrdata;
    logic [1:0]  f16_state;

    always #5 clk = ~clk;

    header_writer_param u_be (
        .clk(clk), .rst(rst), .start(start),
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
        .wr_ready(wr_ready), .wren(be_wren), .addr(be_addr), .wrdata(be_wrdata),
        .busy(be_busy), .done(be_done), .err(be_err), .state_dbg(be_state)
    );

    header_writer_param #(.BIG_ENDIAN(1'b0)) u_le (
        .clk(clk), .rst(rst), .start(start),
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
        .wr_ready(wr_ready), .wren(le_wren), .addr(le_addr), .wrdata(le_wrdata),
        .busy(le_busy), .done(le_done), .err(le_err), .state_dbg(le_state)
    );

    header_writer_param #(.FIELD_BYTES(2), .WORD_W(16)) u_f16 (
        .clk(clk), .rst(rst), .start(start),
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
        .wr_ready(wr_ready), .wren(f16_wren), .addr(f16_addr), .wrdata(f16_wrdata),
        .busy(f16_busy), .done(f16_done), .err(f16_err), .state_dbg(f16_state)
    );

    typedef struct {
        logic [10:0] x0, x1, y0, y1;
        logic [31:0] w, h, a;
        logic        err;
        logic [15:0] w16, h16, a16;
        logic        err16;
    } vec_t;

    vec_t vecs [7];

    int tests = 0;
    int fails = 0;

    logic [7:0]  exp_q    [$];
    logic [7:0]  exp_le_q [$];
    logic [15:0] exp16_q  [$];
    logic [31:0] cap_be_q [$];
    logic [31:0] cap_le_q [$];
    logic [39:0] cap16_q  [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic build_exp(input int vi);
        logic [31:0] fv;
        exp_q.delete();
        exp_le_q.delete();
        exp16_q.delete();
        for (int f = 0; f < 3; f++) begin
            fv = (f == 0) ? vecs[vi].w : (f == 1) ? vecs[vi].h : vecs[vi].a;
            for (int j = 0; j < 4; j++) begin
                exp_q.push_back(8'(fv >> (8 * (3 - j))));
                exp_le_q.push_back(8'(fv >> (8 * j)));
            end
        end
        exp16_q.push_back(vecs[vi].w16);
        exp16_q.push_back(vecs[vi].h16);
        exp16_q.push_back(vecs[vi].a16);
    endtask

    // One header transaction; optional stall window, reset cycle, or ignored restart.
    task automatic run_txn(input int vi, input int stall_cyc, input int stall_len,
                           input int rst_cyc, input int restart_cyc, input int alt_vi);
        int d_be, d_le, d_16, hold5;
        string tag;
        tag = $sformatf("v%0d_s%0d_r%0d_x%0d", vi, stall_cyc, rst_cyc, restart_cyc);
        d_be = -1; d_le = -1; d_16 = -1; hold5 = 0;
        cap_be_q.delete(); cap_le_q.delete(); cap16_q.delete();
        build_exp(vi);
        @(negedge clk);
        x_min = vecs[vi].x0; x_max = vecs[vi].x1;
        y_min = vecs[vi].y0; y_max = vecs[vi].y1;
        wr_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            wr_ready = !(stall_cyc != 0 && c >= stall_cyc && c < stall_cyc + stall_len);
            start = (restart_cyc != 0 && c == restart_cyc);
            if (start) begin
                x_min = vecs[alt_vi].x0; x_max = vecs[alt_vi].x1;
                y_min = vecs[alt_vi].y0; y_max = vecs[alt_vi].y1;
            end
            #1;
            if (c == rst_cyc) begin
                rst = 1'b1;
                #1;
                check({tag, "_rst_wren"}, {be_wren, le_wren, f16_wren}, 3'b000);
                check({tag, "_rst_addr"}, be_addr, 24'h0);
                check({tag, "_rst_wrdata"}, be_wrdata, 8'h0);
                check({tag, "_rst_flags"}, {be_busy, be_done, be_err, f16_done, f16_err}, 5'b0);
                check({tag, "_rst_state"}, be_state, 2'd0);
                break;
            end
            if (c == 1) check({tag, "_calc_busy_wren"}, {be_busy, be_wren}, 2'b10);
            if (be_wren && wr_ready) cap_be_q.push_back({be_addr, be_wrdata});
            if (le_wren && wr_ready) cap_le_q.push_back({le_addr, le_wrdata});
            if (f16_wren && wr_ready) cap16_q.push_back({f16_addr, f16_wrdata});
            if (be_wren && be_addr == 24'd5) hold5++;
            if (be_done && d_be < 0) d_be = c;
            if (le_done && d_le < 0) d_le = c;
            if (f16_done && d_16 < 0) d_16 = c;
            if (rst_cyc == 0 && d_be > 0 && d_le > 0 && d_16 > 0) break;
        end
        start = 1'b0;
        wr_ready = 1'b1;
        if (rst_cyc != 0) begin
            check({tag, "_partial_count"}, cap_be_q.size(), 6);
            for (int k = 0; k < cap_be_q.size() && k < 6; k++)
                check($sformatf("%s_partial_beat%0d", tag, k), cap_be_q[k], {24'(k), exp_q.pop_front()});
            @(posedge clk);
            #1 check({tag, "_rst_hold_wren"}, be_wren, 1'b0);
            @(negedge clk);
            rst = 1'b0;
            repeat (3) @(negedge clk);
            check({tag, "_post_rst_idle"}, {be_wren, be_busy, be_done, be_state}, 5'b0);
        end else begin
            check({tag, "_be_count"}, cap_be_q.size(), 12);
            for (int k = 0; k < cap_be_q.size() && k < 12; k++)
                check($sformatf("%s_be_beat%0d", tag, k), cap_be_q[k], {24'(k), exp_q.pop_front()});
            check({tag, "_le_count"}, cap_le_q.size(), 12);
            for (int k = 0; k < cap_le_q.size() && k < 12; k++)
                check($sformatf("%s_le_beat%0d", tag, k), cap_le_q[k], {24'(k), exp_le_q.pop_front()});
            check({tag, "_f16_count"}, cap16_q.size(), 3);
            for (int k = 0; k < cap16_q.size() && k < 3; k++)
                check($sformatf("%s_f16_beat%0d", tag, k), cap16_q[k], {24'(k), exp16_q.pop_front()});
            check({tag, "_be_done_cyc"}, d_be, 14 + stall_len);
            check({tag, "_le_done_cyc"}, d_le, 14 + stall_len);
            check({tag, "_f16_done_cyc"}, d_16, 5);
            check({tag, "_addr5_cycles"}, hold5, 1 + stall_len);
            check({tag, "_be_err"}, be_err, vecs[vi].err);
            check({tag, "_le_err"}, le_err, vecs[vi].err);
            check({tag, "_f16_err"}, f16_err, vecs[vi].err16);
            check({tag, "_done_outputs"}, {be_wren, be_busy, be_addr, be_wrdata}, 34'h0);
        end
    endtask

    initial begin
        vecs[0] = '{11'd0,    11'd640,  11'd0,    11'd480,
                    32'h280, 32'h1E0, 32'h4B000,  1'b0, 16'h280, 16'h1E0, 16'hFFFF, 1'b1};
        vecs[1] = '{11'd100,  11'd50,   11'd0,    11'd10,
                    32'h0,   32'hA,   32'h0,      1'b1, 16'h0,   16'hA,   16'h0,    1'b1};
        vecs[2] = '{11'd0,    11'd2047, 11'd0,    11'd2047,
                    32'h7FF, 32'h7FF, 32'h3FF001, 1'b0, 16'h7FF, 16'h7FF, 16'hFFFF, 1'b1};
        vecs[3] = '{11'd10,   11'd10,   11'd5,    11'd300,
                    32'h0,   32'h127, 32'h0,      1'b0, 16'h0,   16'h127, 16'h0,    1'b0};
        vecs[4] = '{11'd0,    11'd255,  11'd0,    11'd257,
                    32'hFF,  32'h101, 32'hFFFF,   1'b0, 16'hFF,  16'h101, 16'hFFFF, 1'b0};
        vecs[5] = '{11'd0,    11'd256,  11'd0,    11'd256,
                    32'h100, 32'h100, 32'h10000,  1'b0, 16'h100, 16'h100, 16'hFFFF, 1'b1};
        vecs[6] = '{11'd1234, 11'd1234, 11'd2000, 11'd100,
                    32'h0,   32'h0,   32'h0,      1'b1, 16'h0,   16'h0,   16'h0,    1'b1};

        #12;
        check("reset_outputs", {be_wren, be_addr, be_wrdata, be_busy, be_done, be_err}, 36'h0);
        check("reset_state", {be_state, le_state, f16_state}, 6'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int vi = 0; vi < 7; vi++) run_txn(vi, 0, 0, 0, 0, 0);
        run_txn(0, 7, 3, 0, 0, 0);
        run_txn(2, 0, 0, 0, 3, 5);
        run_txn(0, 0, 0, 8, 0, 0);
        run_txn(0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
